// File: rtl/iroh_mem_pkg.sv
// Shared types and constants for the internal_mem initiator path.
// Address/data widths match the internal_mem port.
package iroh_mem_pkg;

   localparam int ADDR_W           = 8;
   localparam int DATA_W           = 16;
   localparam int MAX_READ_LATENCY = 4;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RD_ISSUE,
      RD_WAIT,
      RD_RESP
   } mreq_state_t;

endpackage

// File: rtl/mem_requester.sv
// Initiator for internal_mem: single writes and 1..16 word read bursts,
// with a backpressured response channel.
module mem_requester
   import iroh_mem_pkg::*;
#(
   parameter int ADDR_W       = iroh_mem_pkg::ADDR_W,
   parameter int DATA_W       = iroh_mem_pkg::DATA_W,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [3:0]        req_len,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              wr_done,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_enable,
   output logic              mem_wEnable,
   output logic [DATA_W-1:0] mem_newWord,
   input  logic [DATA_W-1:0] mem_wordOut
);

   localparam int LAT_W = $clog2(MAX_READ_LATENCY);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

   mreq_state_t       state_q;
   logic [ADDR_W-1:0] cur_addr_q;
   logic [3:0]        remain_q;
   logic [LAT_W-1:0]  lat_cnt_q;
   logic              wr_done_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_last_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_enable_q;
   logic              mem_wEnable_q;
   logic [DATA_W-1:0] mem_newWord_q;

   assign req_ready   = (state_q == IDLE) && !rst;
   assign wr_done     = wr_done_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_last    = rsp_last_q;
   assign mem_addr    = mem_addr_q;
   assign mem_enable  = mem_enable_q;
   assign mem_wEnable = mem_wEnable_q;
   assign mem_newWord = mem_newWord_q;

   // Pin values for each cycle are set on the edge that enters the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cur_addr_q    <= '0;
         remain_q      <= '0;
         lat_cnt_q     <= '0;
         wr_done_q     <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_last_q    <= 1'b0;
         mem_addr_q    <= '0;
         mem_enable_q  <= 1'b0;
         mem_wEnable_q <= 1'b0;
         mem_newWord_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  cur_addr_q   <= req_addr;
                  mem_addr_q   <= req_addr;
                  mem_enable_q <= 1'b1;
                  if (req_write) begin
                     remain_q      <= '0;
                     mem_wEnable_q <= 1'b1;
                     mem_newWord_q <= req_wdata;
                     wr_done_q     <= 1'b1;
                     state_q       <= WRITE;
                  end else begin
                     remain_q <= req_len;
                     state_q  <= RD_ISSUE;
                  end
               end
            end
            WRITE: begin
               mem_enable_q  <= 1'b0;
               mem_wEnable_q <= 1'b0;
               wr_done_q     <= 1'b0;
               state_q       <= IDLE;
            end
            RD_ISSUE: begin
               mem_enable_q <= 1'b0;
               lat_cnt_q    <= LAT_INIT;
               state_q      <= RD_WAIT;
            end
            RD_WAIT: begin
               if (lat_cnt_q == '0) begin
                  rsp_data_q  <= mem_wordOut;
                  rsp_valid_q <= 1'b1;
                  rsp_last_q  <= (remain_q == '0);
                  state_q     <= RD_RESP;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 1'b1;
               end
            end
            RD_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_last_q  <= 1'b0;
                  if (remain_q == '0) begin
                     state_q <= IDLE;
                  end else begin
                     remain_q     <= remain_q - 1'b1;
                     cur_addr_q   <= cur_addr_q + 1'b1;
                     mem_addr_q   <= cur_addr_q + 1'b1;
                     mem_enable_q <= 1'b1;
                     state_q      <= RD_ISSUE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester paired with a behavioural internal_mem
// (one-cycle read latency) and a queue-based reference model.
module tb_mem_requester;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [3:0]  req_len = '0;
   logic [15:0] req_wdata = '0;
   logic        wr_done;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_data;
   logic        rsp_last;
   logic [7:0]  mem_addr;
   logic        mem_enable;
   logic        mem_wEnable;
   logic [15:0] mem_newWord;
   logic [15:0] mem_wordOut;

   mem_requester #(.READ_LATENCY(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr),
      .req_len(req_len), .req_wdata(req_wdata),
      .wr_done(wr_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_last(rsp_last),
      .mem_addr(mem_addr), .mem_enable(mem_enable),
      .mem_wEnable(mem_wEnable), .mem_newWord(mem_newWord),
      .mem_wordOut(mem_wordOut)
   );

   always #5 clk = ~clk;

   // behavioural internal_mem
   logic [15:0] mem [256];
   logic        mem_clr = 1'b1;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         mem_wordOut <= '0;
      end else if (mem_enable) begin
         if (mem_wEnable) mem[mem_addr] <= mem_newWord;
         else mem_wordOut <= mem[mem_addr];
      end
   end

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } exp_t;
   typedef struct packed {
      logic [7:0]  a;
      logic [15:0] d;
   } wr_t;

   logic [15:0] ref_mem [256];
   exp_t        exp_q[$];
   wr_t         wr_q[$];
   logic [7:0]  addr_q[$];

   int checks = 0;
   int failures = 0;
   int mode = 0;
   int stall_left = 0;
   int burst_idx = 0;
   int got_n = 0;
   int rd_pulses = 0;
   int wen_cycles = 0;
   int accept_got_n = 0;
   logic [15:0] got_first = '0;
   logic [15:0] got_lastd = '0;
   logic        held_v = 1'b0;
   logic [15:0] held_d = '0;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      wr_t  w;
      logic [7:0] ea;
      if (!rst) begin
         if (rsp_valid && mode == 2 && burst_idx == 1 && stall_left > 0) begin
            rsp_ready = 1'b0;
            stall_left--;
         end else if (mode == 1) begin
            rsp_ready = 1'($urandom_range(0, 1));
         end else begin
            rsp_ready = 1'b1;
         end
         if (rsp_valid && held_v) chk("rsp_hold", rsp_data, held_d);
         held_v = rsp_valid && !rsp_ready;
         held_d = rsp_data;
         if (rsp_valid) chk("enable_in_resp", mem_enable, 0);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_data", rsp_data, e.data);
               chk("rsp_last", rsp_last, e.last);
            end
            got_n++;
            if (got_n == 1) got_first = rsp_data;
            got_lastd = rsp_data;
            burst_idx = rsp_last ? 0 : burst_idx + 1;
         end
         if (mem_wEnable) begin
            wen_cycles++;
            chk("wr_enable", mem_enable, 1);
            chk("wr_done", wr_done, 1);
            chk("wr_during_read", exp_q.size(), 0);
            if (wr_q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               w = wr_q.pop_front();
               chk("wr_addr", mem_addr, w.a);
               chk("wr_data", mem_newWord, w.d);
            end
         end else if (wr_done) begin
            chk("wr_done_stray", 1, 0);
         end
         if (mem_enable && !mem_wEnable) begin
            rd_pulses++;
            if (addr_q.size() == 0) begin
               chk("unexpected_read", 1, 0);
            end else begin
               ea = addr_q.pop_front();
               chk("rd_addr", mem_addr, ea);
            end
         end
      end
   end

   task automatic do_req(input logic w, input logic [7:0] a,
                         input logic [3:0] l, input logic [15:0] d,
                         input logic keep);
      int n;
      logic [7:0] ai;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_len   = l;
      req_wdata = d;
      n = 0;
      while (!req_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk("req_timeout", 1, 0);
         req_valid = 1'b0;
         return;
      end
      if (w) begin
         ref_mem[a] = d;
         wr_q.push_back('{a: a, d: d});
      end else begin
         for (int i = 0; i <= int'(l); i++) begin
            ai = a + 8'(i);
            addr_q.push_back(ai);
            exp_q.push_back('{data: ref_mem[ai], last: (i == int'(l))});
         end
      end
      accept_got_n = got_n;
      @(posedge clk);
      #1;
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((!req_ready || rsp_valid || exp_q.size() != 0 ||
              wr_q.size() != 0 || addr_q.size() != 0) && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (n >= 600) chk("done_timeout", 1, 0);
   endtask

   typedef struct {
      logic        w;
      logic [7:0]  a;
      logic [3:0]  l;
      logic [15:0] d;
      int          stall;
      int          exp_n;
      logic [15:0] exp_first;
      logic [15:0] exp_last;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int cnt;
      int n;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;

      vecs[0]  = '{1'b1, 8'h12, 4'd0, 16'd50000, 0, 0, 16'd0, 16'd0};
      vecs[1]  = '{1'b0, 8'h12, 4'd0, 16'd0, 0, 1, 16'd50000, 16'd50000};
      vecs[2]  = '{1'b1, 8'h20, 4'd0, 16'd1, 0, 0, 16'd0, 16'd0};
      vecs[3]  = '{1'b1, 8'h21, 4'd0, 16'd2, 0, 0, 16'd0, 16'd0};
      vecs[4]  = '{1'b1, 8'h22, 4'd0, 16'd3, 0, 0, 16'd0, 16'd0};
      vecs[5]  = '{1'b1, 8'h23, 4'd0, 16'd4, 0, 0, 16'd0, 16'd0};
      vecs[6]  = '{1'b0, 8'h20, 4'd3, 16'd0, 0, 4, 16'd1, 16'd4};
      vecs[7]  = '{1'b0, 8'h20, 4'd3, 16'd0, 3, 4, 16'd1, 16'd4};
      vecs[8]  = '{1'b1, 8'hFE, 4'd0, 16'd11, 0, 0, 16'd0, 16'd0};
      vecs[9]  = '{1'b1, 8'hFF, 4'd0, 16'd22, 0, 0, 16'd0, 16'd0};
      vecs[10] = '{1'b1, 8'h00, 4'd0, 16'd33, 0, 0, 16'd0, 16'd0};
      vecs[11] = '{1'b1, 8'h01, 4'd0, 16'd44, 0, 0, 16'd0, 16'd0};
      vecs[12] = '{1'b0, 8'hFE, 4'd3, 16'd0, 0, 4, 16'd11, 16'd44};

      #3;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_mem_enable", mem_enable, 0);
      chk("rst_mem_wEnable", mem_wEnable, 0);
      chk("rst_wr_done", wr_done, 0);
      chk("rst_mem_addr", mem_addr, 0);
      @(posedge clk);
      #2;
      mem_clr = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", req_ready, 1);

      foreach (vecs[k]) begin
         got_n = 0;
         rd_pulses = 0;
         wen_cycles = 0;
         held_v = 1'b0;
         stall_left = vecs[k].stall;
         mode = (vecs[k].stall > 0) ? 2 : 0;
         do_req(vecs[k].w, vecs[k].a, vecs[k].l, vecs[k].d, 1'b0);
         wait_done();
         if (vecs[k].w) begin
            chk("vec_wen_cycles", wen_cycles, 1);
         end else begin
            chk("vec_rsp_count", got_n, vecs[k].exp_n);
            chk("vec_first", got_first, vecs[k].exp_first);
            chk("vec_last", got_lastd, vecs[k].exp_last);
            chk("vec_rd_pulses", rd_pulses, vecs[k].exp_n);
         end
      end

      // write held on req_valid behind a burst
      mode = 0;
      got_n = 0;
      do_req(1'b0, 8'h20, 4'd3, 16'd0, 1'b1);
      do_req(1'b1, 8'h30, 4'd0, 16'h7777, 1'b0);
      chk("queued_accept_after", accept_got_n, 4);
      wait_done();
      got_n = 0;
      do_req(1'b0, 8'h30, 4'd0, 16'd0, 1'b0);
      wait_done();
      chk("queued_write_data", got_first, 16'h7777);

      // reset during the wait phase of word 2
      do_req(1'b0, 8'h40, 4'd7, 16'd0, 1'b0);
      cnt = 0;
      n = 0;
      while (cnt < 2 && n < 200) begin
         if (mem_enable) cnt++;
         if (cnt < 2) begin
            @(negedge clk);
            n++;
         end
      end
      chk("abort_reach_word2", cnt, 2);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_mem_enable", mem_enable, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_wr_done", wr_done, 0);
      chk("abort_req_ready", req_ready, 0);
      exp_q.delete();
      addr_q.delete();
      wr_q.delete();
      burst_idx = 0;
      held_v = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_ready_after", req_ready, 1);
      got_n = 0;
      do_req(1'b0, 8'h20, 4'd3, 16'd0, 1'b0);
      wait_done();
      chk("abort_next_count", got_n, 4);
      chk("abort_next_first", got_first, 16'd1);
      chk("abort_next_last", got_lastd, 16'd4);

      // randomized traffic with random response backpressure
      mode = 1;
      for (int r = 0; r < 60; r++) begin
         logic [7:0] a;
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255))
                                         : 8'($urandom);
         do_req(($urandom_range(0, 2) == 0), a, 4'($urandom),
                16'($urandom), 1'b0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_done();
      chk("rand_drained", exp_q.size() + wr_q.size() + addr_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
